// File: rtl/async_fifo.sv
// async_fifo -- dual-clock FIFO built on Gray-coded pointers.
//
// Purpose:
//   Moves DATA_WIDTH-bit words from the writer_clk domain to the reader_clk
//   domain through a DEPTH = 2**ADDR_LEN entry dual-port memory. Each side
//   keeps an (ADDR_LEN+1)-bit binary pointer plus its registered Gray-code
//   copy. Only the Gray copy crosses into the other domain, through a
//   multi-flop synchronizer. Full and empty are computed from the local
//   pointer and the synchronized remote pointer. The remote pointer is always
//   stale, so the flags can only err on the safe side.
//
// Ports:
//   reader_clk          in   read-domain clock
//   reader_rst_i        in   read-domain synchronous reset, active-high
//   reader_deq_i        in   dequeue request (ignored while empty)
//   reader_q_o          out  registered dequeued data, holds between reads
//   reader_empty_o      out  no entries visible to the reader
//   reader_alm_empty_o  out  at most one entry visible to the reader
//   writer_clk          in   write-domain clock, asynchronous to reader_clk
//   writer_rst_i        in   write-domain synchronous reset, active-high
//   writer_enq_i        in   enqueue request (ignored while full)
//   writer_d_i          in   enqueue data
//   writer_full_o       out  no free slot visible to the writer
//   writer_alm_full_o   out  at most one free slot visible to the writer
//
// Configuration macro:
//   ASYNC_FIFO_SYNC3_EN  when defined, both synchronizers use 3 flops instead
//                        of 2. This adds one cycle of flag latency.
`timescale 1ns/1ps

module async_fifo #(
  parameter int ADDR_LEN   = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  reader_clk,
  input  logic                  reader_rst_i,
  input  logic                  reader_deq_i,
  output logic [DATA_WIDTH-1:0] reader_q_o,
  output logic                  reader_empty_o,
  output logic                  reader_alm_empty_o,
  input  logic                  writer_clk,
  input  logic                  writer_rst_i,
  input  logic                  writer_enq_i,
  input  logic [DATA_WIDTH-1:0] writer_d_i,
  output logic                  writer_full_o,
  output logic                  writer_alm_full_o
);

  localparam int DEPTH = 1 << ADDR_LEN;
  localparam int PTR_W = ADDR_LEN + 1;
`ifdef ASYNC_FIFO_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif
  localparam logic [PTR_W-1:0] DEPTH_P    = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_M1_P = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE_P      = PTR_W'(1);

  // Storage. Memory contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- writer
  logic [PTR_W-1:0] wptr_bin_reg;
  logic [PTR_W-1:0] wptr_bin_next;
  logic [PTR_W-1:0] wptr_gray_reg;
  logic [PTR_W-1:0] wptr_gray_next;
  logic [PTR_W-1:0] rptr_sync_reg [SYNC_STAGES];
  logic [PTR_W-1:0] rptr_sync_last;
  logic [PTR_W-1:0] rptr_sync_bin;
  logic [PTR_W-1:0] count_w;
  logic             write_en;

  // ---------------------------------------------------------------- reader
  logic [PTR_W-1:0]      rptr_bin_reg;
  logic [PTR_W-1:0]      rptr_bin_next;
  logic [PTR_W-1:0]      rptr_gray_reg;
  logic [PTR_W-1:0]      rptr_gray_next;
  logic [PTR_W-1:0]      wptr_sync_reg [SYNC_STAGES];
  logic [PTR_W-1:0]      wptr_sync_last;
  logic [PTR_W-1:0]      wptr_sync_bin;
  logic [PTR_W-1:0]      count_r;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] q_reg;

  // ============================ write domain =============================
  assign write_en       = writer_enq_i & ~writer_full_o;
  assign wptr_bin_next  = wptr_bin_reg + ONE_P;
  assign wptr_gray_next = wptr_bin_next ^ (wptr_bin_next >> 1);

  always_ff @(posedge writer_clk) begin
    if (writer_rst_i) begin
      wptr_bin_reg  <= '0;
      wptr_gray_reg <= '0;
    end else if (write_en) begin
      wptr_bin_reg  <= wptr_bin_next;
      wptr_gray_reg <= wptr_gray_next;
    end
  end

  always_ff @(posedge writer_clk) begin
    if (write_en) begin
      mem[wptr_bin_reg[ADDR_LEN-1:0]] <= writer_d_i;
    end
  end

  // The read-side Gray pointer enters the write domain here. It is taken
  // straight from a register, so at most one bit changes per reader edge.
  always_ff @(posedge writer_clk) begin
    if (writer_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rptr_sync_reg[i] <= '0;
      end
    end else begin
      rptr_sync_reg[0] <= rptr_gray_reg;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rptr_sync_reg[i] <= rptr_sync_reg[i-1];
      end
    end
  end

  assign rptr_sync_last = rptr_sync_reg[SYNC_STAGES-1];

  // The synchronized read pointer lags the real one. The occupancy the
  // writer computes is therefore never lower than the truth, which keeps
  // both full flags pessimistic.
  assign count_w           = wptr_bin_reg - rptr_sync_bin;
  assign writer_full_o     = (count_w == DEPTH_P);
  assign writer_alm_full_o = (count_w >= DEPTH_M1_P);

  // ============================ read domain ==============================
  assign read_en        = reader_deq_i & ~reader_empty_o;
  assign rptr_bin_next  = rptr_bin_reg + ONE_P;
  assign rptr_gray_next = rptr_bin_next ^ (rptr_bin_next >> 1);

  always_ff @(posedge reader_clk) begin
    if (reader_rst_i) begin
      rptr_bin_reg  <= '0;
      rptr_gray_reg <= '0;
      q_reg         <= '0;
    end else if (read_en) begin
      rptr_bin_reg  <= rptr_bin_next;
      rptr_gray_reg <= rptr_gray_next;
      q_reg         <= mem[rptr_bin_reg[ADDR_LEN-1:0]];
    end
  end

  assign reader_q_o = q_reg;

  always_ff @(posedge reader_clk) begin
    if (reader_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        wptr_sync_reg[i] <= '0;
      end
    end else begin
      wptr_sync_reg[0] <= wptr_gray_reg;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wptr_sync_reg[i] <= wptr_sync_reg[i-1];
      end
    end
  end

  assign wptr_sync_last = wptr_sync_reg[SYNC_STAGES-1];

  // Gray-to-binary conversion. Binary bit i is the XOR of all Gray bits at
  // position i and above.
  genvar gi;
  generate
    for (gi = 0; gi < PTR_W; gi++) begin : g_gray2bin
      assign rptr_sync_bin[gi] = ^rptr_sync_last[PTR_W-1:gi];
      assign wptr_sync_bin[gi] = ^wptr_sync_last[PTR_W-1:gi];
    end
  endgenerate

  // The synchronized write pointer lags the real one. The occupancy the
  // reader computes is therefore never higher than the truth, which keeps
  // both empty flags pessimistic.
  assign count_r            = wptr_sync_bin - rptr_bin_reg;
  assign reader_empty_o     = (count_r == '0);
  assign reader_alm_empty_o = (count_r <= ONE_P);

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo -- self-checking bench for async_fifo.
// The reference model is a queue holding the words the FIFO really contains.
// Writes are pushed when accepted and reads are popped when accepted. Flags
// are checked for pessimism against the true queue occupancy.
`timescale 1ns/1ps

module tb_async_fifo;

  localparam int AL    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AL;
  localparam int N_RND = 4000;

  logic          reader_clk;
  logic          reader_rst_i;
  logic          reader_deq_i;
  logic [DW-1:0] reader_q_o;
  logic          reader_empty_o;
  logic          reader_alm_empty_o;
  logic          writer_clk;
  logic          writer_rst_i;
  logic          writer_enq_i;
  logic [DW-1:0] writer_d_i;
  logic          writer_full_o;
  logic          writer_alm_full_o;

  async_fifo #(.ADDR_LEN(AL), .DATA_WIDTH(DW)) dut (
    .reader_clk         (reader_clk),
    .reader_rst_i       (reader_rst_i),
    .reader_deq_i       (reader_deq_i),
    .reader_q_o         (reader_q_o),
    .reader_empty_o     (reader_empty_o),
    .reader_alm_empty_o (reader_alm_empty_o),
    .writer_clk         (writer_clk),
    .writer_rst_i       (writer_rst_i),
    .writer_enq_i       (writer_enq_i),
    .writer_d_i         (writer_d_i),
    .writer_full_o      (writer_full_o),
    .writer_alm_full_o  (writer_alm_full_o)
  );

  // The writer clock has a 20 ns period. The reader clock has a 10 ns period
  // and is offset by 3 ns so that the edges of the two clocks never coincide.
  initial begin
    writer_clk = 1'b0;
    forever #10 writer_clk = ~writer_clk;
  end
  initial begin
    reader_clk = 1'b0;
    #3;
    forever #5 reader_clk = ~reader_clk;
  end

  int            n_cmp;
  int            n_fail;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] last_q;

  // Shared between steps and fork branches.
  logic          w_acc;
  logic          r_acc;
  logic [DW-1:0] r_val;
  int            k;
  int            nacc;
  int            wv;
  int            wc;
  int            rc;
  int            got;
  int            prev;
  int            sum_in;
  int            sum_out;
  int            sent;
  logic          w_done;
  logic          saw_full;
  logic          saw_empty;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one writer cycle. Whether the DUT accepts the word follows from the
  // full flag, which is stable between writer edges.
  task automatic w_cycle(input logic en, input logic [DW-1:0] d, output logic acc);
    writer_enq_i = en;
    writer_d_i   = d;
    acc          = en && (writer_full_o === 1'b0);
    @(posedge writer_clk);
    #1;
    writer_enq_i = 1'b0;
    if (acc) model_q.push_back(d);
    if (model_q.size() >= DEPTH)     check("full_at_depth", 32'(writer_full_o), 32'd1);
    if (model_q.size() >= DEPTH - 1) check("alm_full_at_depth_m1", 32'(writer_alm_full_o), 32'd1);
  endtask

  // Runs one reader cycle. The word read becomes visible just after the
  // accepting edge.
  task automatic r_cycle(input logic en, output logic acc, output logic [DW-1:0] val);
    logic [DW-1:0] exp;
    reader_deq_i = en;
    acc          = en && (reader_empty_o === 1'b0);
    @(posedge reader_clk);
    #1;
    reader_deq_i = 1'b0;
    val          = reader_q_o;
    if (acc) begin
      check("underflow", 32'(model_q.size() == 0), 32'd0);
      if (model_q.size() != 0) begin
        exp = model_q.pop_front();
        check("read_data", reader_q_o, exp);
        last_q = exp;
      end
    end else begin
      check("q_hold", reader_q_o, last_q);
    end
    if (model_q.size() == 0) check("empty_when_drained", 32'(reader_empty_o), 32'd1);
    if (model_q.size() <= 1) check("alm_empty_at_le1", 32'(reader_alm_empty_o), 32'd1);
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    last_q       = '0;
    reader_rst_i = 1'b1;
    writer_rst_i = 1'b1;
    reader_deq_i = 1'b0;
    writer_enq_i = 1'b0;
    writer_d_i   = '0;

    // ---- Step 1: reset state.
    repeat (4) @(posedge writer_clk);
    #1;
    reader_rst_i = 1'b0;
    writer_rst_i = 1'b0;
    repeat (3) @(posedge writer_clk);
    #1;
    check("rst_empty",     32'(reader_empty_o),     32'd1);
    check("rst_alm_empty", 32'(reader_alm_empty_o), 32'd1);
    check("rst_full",      32'(writer_full_o),      32'd0);
    check("rst_alm_full",  32'(writer_alm_full_o),  32'd0);
    check("rst_q",         reader_q_o,              32'd0);
    $display("step reset: empty=%0b alm_empty=%0b full=%0b alm_full=%0b q=%0h",
             reader_empty_o, reader_alm_empty_o, writer_full_o, writer_alm_full_o, reader_q_o);

    // ---- Step 2: a single word travels through the FIFO.
    w_cycle(1'b1, 32'h5, w_acc);
    check("enq5_accepted", 32'(w_acc), 32'd1);
    k = 0;
    while (reader_empty_o !== 1'b0 && k < 4) begin
      @(posedge reader_clk);
      #1;
      k++;
    end
    check("empty_clears_within_4", 32'(reader_empty_o), 32'd0);
    check("alm_empty_one_entry",   32'(reader_alm_empty_o), 32'd1);
    r_cycle(1'b1, r_acc, r_val);
    check("deq5_accepted",     32'(r_acc), 32'd1);
    check("q_is_5",            r_val,      32'h5);
    check("empty_after_deq",   32'(reader_empty_o), 32'd1);
    $display("step single: empty cleared after %0d reader cycles, q=%0h", k, r_val);

    // ---- Step 3: fill the FIFO while the reader idles, then drain it.
    repeat (10) @(posedge writer_clk);
    #1;
    nacc = 0;
    for (int i = 0; i < DEPTH - 2; i++) begin
      w_cycle(1'b1, $urandom, w_acc);
      if (w_acc) nacc++;
    end
    check("fill_accepts_1022",   32'(nacc), 32'(DEPTH - 2));
    check("alm_full_low_at_1022", 32'(writer_alm_full_o), 32'd0);
    check("full_low_at_1022",     32'(writer_full_o),     32'd0);
    w_cycle(1'b1, $urandom, w_acc);
    check("alm_full_at_1023",     32'(writer_alm_full_o), 32'd1);
    check("full_low_at_1023",     32'(writer_full_o),     32'd0);
    w_cycle(1'b1, $urandom, w_acc);
    check("full_at_1024",         32'(writer_full_o),     32'd1);
    w_cycle(1'b1, 32'hDEAD, w_acc);
    check("dead_dropped",         32'(model_q.size()),    32'(DEPTH));
    check("full_stays",           32'(writer_full_o),     32'd1);
    k = 0;
    while (model_q.size() > 0 && k < 3000) begin
      r_cycle(1'b1, r_acc, r_val);
      k++;
    end
    check("drain_done", 32'(model_q.size()), 32'd0);
    repeat (4) @(posedge writer_clk);
    #1;
    check("full_clears_after_drain",     32'(writer_full_o),     32'd0);
    check("alm_full_clears_after_drain", 32'(writer_alm_full_o), 32'd0);
    check("empty_after_drain",           32'(reader_empty_o),    32'd1);
    $display("step fill/drain: accepted=%0d drained in %0d reader cycles", nacc + 2, k);

    // ---- Step 4: the reader starts late, and the writer is throttled by
    // its almost-full flag.
    sum_in  = 0;
    sum_out = 0;
    got     = 0;
    prev    = 0;
    fork
      begin
        wv = 1;
        wc = 0;
        while (wv <= 1035 && wc < 10000) begin
          w_cycle(writer_alm_full_o === 1'b0, 32'(wv), w_acc);
          if (w_acc) begin
            sum_in += wv;
            wv++;
          end
          wc++;
        end
      end
      begin
        repeat (3072) @(posedge reader_clk);
        #1;
        rc = 0;
        while (got < 1035 && rc < 10000) begin
          r_cycle(reader_empty_o === 1'b0, r_acc, r_val);
          if (r_acc) begin
            check("in_order", r_val, 32'(prev + 1));
            prev = int'(r_val);
            sum_out += int'(r_val);
            got++;
          end
          rc++;
        end
      end
    join
    check("got_1035", 32'(got),     32'd1035);
    check("sum_in",   32'(sum_in),  32'd536130);
    check("sum_out",  32'(sum_out), 32'd536130);
    $display("step throttled: got=%0d sum_in=%0d sum_out=%0d", got, sum_in, sum_out);

    // ---- Step 5: random interleaved traffic across several pointer wraps.
    // The reader alternates between slow and fast phases so that the FIFO
    // swings between full and empty.
    sent      = 0;
    got       = 0;
    w_done    = 1'b0;
    saw_full  = 1'b0;
    saw_empty = 1'b0;
    fork
      begin
        wc = 0;
        while (sent < N_RND && wc < 30000) begin
          if (writer_full_o === 1'b1) saw_full = 1'b1;
          w_cycle(($urandom % 4) != 0, $urandom, w_acc);
          if (w_acc) sent++;
          wc++;
        end
        w_done = 1'b1;
      end
      begin
        rc = 0;
        while ((!w_done || model_q.size() > 0) && rc < 60000) begin
          if (reader_empty_o === 1'b1 && got > 0) saw_empty = 1'b1;
          if (w_done || ((rc / 5000) % 2) == 1)
            r_cycle(($urandom % 8) != 0, r_acc, r_val);
          else
            r_cycle(($urandom % 8) == 0, r_acc, r_val);
          if (r_acc) got++;
          rc++;
        end
      end
    join
    check("rnd_sent",      32'(sent),            32'(N_RND));
    check("rnd_received",  32'(got),             32'(N_RND));
    check("rnd_model_end", 32'(model_q.size()),  32'd0);
    check("rnd_saw_full",  32'(saw_full),        32'd1);
    check("rnd_saw_empty", 32'(saw_empty),       32'd1);
    check("rnd_empty_end", 32'(reader_empty_o),  32'd1);
    $display("step random: sent=%0d received=%0d", sent, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
